// File: rtl/pwrx_pkg.sv
// rtl/pwrx_pkg.sv - shared types and defaults for the pulse-width receiver
package pwrx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwrx_state_t;

  localparam int DEF_MSG_BITS     = 24;
  localparam int DEF_CNT_W        = 7;
  localparam int DEF_ONE_THRESH   = 26;
  localparam int DEF_MIN_PULSE    = 4;
  localparam int DEF_IDLE_TIMEOUT = 100;

  function automatic int bc_width(input int msg_bits);
    return $clog2(msg_bits + 1);
  endfunction

endpackage

// File: rtl/pwrx_sync_edge.sv
// rtl/pwrx_sync_edge.sv - two-flop synchronizer with rise/fall strobes
module pwrx_sync_edge
  import pwrx_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic neo_in,
  output logic line,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= neo_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign line = sync;
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/pwrx_receiver.sv
// rtl/pwrx_receiver.sv - pulse-width serial receiver with holding buffer
// Optional trailing even-parity pulse enabled by PWRX_PARITY_EN.
module pwrx_receiver
  import pwrx_pkg::*;
#(
  parameter int MSG_BITS     = DEF_MSG_BITS,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int ONE_THRESH   = DEF_ONE_THRESH,
  parameter int MIN_PULSE    = DEF_MIN_PULSE,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          neo_in,
  output logic [MSG_BITS-1:0]           msg_data,
  output logic                          msg_valid,
  input  logic                          msg_ack,
  output logic [bc_width(MSG_BITS)-1:0] bit_count,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err
);

  localparam int BC_W = bc_width(MSG_BITS);

  logic line;
  logic rise;
  logic fall;

  pwrx_sync_edge u_sync (
    .clock  (clock),
    .reset  (reset),
    .neo_in (neo_in),
    .line   (line),
    .rise   (rise),
    .fall   (fall)
  );

  pwrx_state_t         state;
  logic [CNT_W-1:0]    cnt;
  logic [MSG_BITS-1:0] shreg;
  logic [BC_W-1:0]     bc;

  logic                new_bit;
  logic                pulse_ok;
  logic                last_bit;
  logic                word_ok;
  logic [MSG_BITS-1:0] shifted;
  logic [MSG_BITS-1:0] word;

  always_comb begin
    new_bit  = cnt > CNT_W'(ONE_THRESH);
    pulse_ok = cnt >= CNT_W'(MIN_PULSE);
    shifted  = (shreg << 1) | MSG_BITS'(new_bit);
`ifdef PWRX_PARITY_EN
    // The data word is already complete; the final pulse only carries parity.
    last_bit = bc == BC_W'(MSG_BITS);
    word     = shreg;
    word_ok  = ((^shreg) ^ new_bit) == 1'b0;
`else
    last_bit = bc == BC_W'(MSG_BITS - 1);
    word     = shifted;
    word_ok  = 1'b1;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (rise || fall) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bc         <= '0;
      msg_data   <= '0;
      msg_valid  <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      if (msg_ack && msg_valid) begin
        msg_valid <= 1'b0;
        overrun   <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (rise) state <= HIGH;
        end
        HIGH: begin
          if (fall) begin
            if (!pulse_ok) begin
              state <= (bc == '0) ? IDLE : LOW;
            end else if (last_bit) begin
              shreg <= '0;
              bc    <= '0;
              state <= IDLE;
              // A same-cycle ack frees the buffer for the new word.
              if (!word_ok) begin
                parity_err <= 1'b1;
              end else if (!msg_valid || msg_ack) begin
                msg_data  <= word;
                msg_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              shreg <= shifted;
              bc    <= bc + BC_W'(1);
              state <= LOW;
            end
          end
        end
        LOW: begin
          if (rise) begin
            state <= HIGH;
          end else if (cnt >= CNT_W'(IDLE_TIMEOUT)) begin
            frame_err <= 1'b1;
            shreg     <= '0;
            bc        <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bit_count = bc;
  assign busy      = (bc != '0) || line;

endmodule
